// File: rtl/seq_load_unit_if.sv
// Bus bundle for seq_load_unit.
// Groups the AXI R beat, the per-beat control (txn), the request meta stream
// and the buffer drain port towards the shuffle unit.
//   slave  : the load unit side (consumes R/txn/meta, produces out/buf_cnt)
//   master : the environment side (AXI, sequencer, shuffle unit)
interface seq_load_unit_if #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned Dlen         = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned NrBufs       = 2
);
  localparam int unsigned BusNbs = AxiDataWidth / 4;
  localparam int unsigned BufNbs = Dlen / 4 * NrLanes;
  localparam int unsigned BW     = $clog2(BusNbs);

  // AXI R channel
  logic                      r_valid;
  logic                      r_ready;
  logic [AxiDataWidth-1:0]   r_data;
  // beat control, consumed together with the R beat
  logic                      txn_valid;
  logic                      txn_ready;
  logic                      txn_head;
  logic                      txn_final;
  logic [7:0]                txn_rmn_beat;
  logic [BW-1:0]             txn_off;
  logic [BW:0]               txn_lbn;
  logic                      txn_gather;
  // request meta
  logic                      meta_valid;
  logic                      meta_ready;
  logic [15:0]               meta_vstart;
  logic [1:0]                meta_sew;
  // drain towards the shuffle unit
  logic                      out_valid;
  logic                      out_ready;
  logic [BufNbs*4-1:0]       out_nb;
  logic [BufNbs-1:0]         out_en;
  logic [$clog2(NrBufs):0]   buf_cnt;

  modport master (
    output r_valid, r_data,
    output txn_valid, txn_head, txn_final, txn_rmn_beat, txn_off, txn_lbn, txn_gather,
    output meta_valid, meta_vstart, meta_sew,
    output out_ready,
    input  r_ready, txn_ready, meta_ready, out_valid, out_nb, out_en, buf_cnt
  );

  modport slave (
    input  r_valid, r_data,
    input  txn_valid, txn_head, txn_final, txn_rmn_beat, txn_off, txn_lbn, txn_gather,
    input  meta_valid, meta_vstart, meta_sew,
    input  out_ready,
    output r_ready, txn_ready, meta_ready, out_valid, out_nb, out_en, buf_cnt
  );
endinterface

// File: rtl/seq_load_unit.sv
// Sequential load data controller.
// Packs nibbles of AXI R beats into a ring of NrBufs lane-wide buffers that
// drain to the shuffle unit. Serial mode streams the valid nibble window of
// each beat; gather mode takes one element per beat. A request only starts
// once its meta (start pointer, sew) is available in the meta FIFO.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : seq_load_unit_if.slave (R, txn, meta, out, buf_cnt)
module seq_load_unit #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned Dlen         = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned NrBufs       = 2,   // power of 2, >= 2
  parameter int unsigned InfoDepth    = 4    // power of 2, >= 2
) (
  input logic            clk_i,
  input logic            rst_ni,
  seq_load_unit_if.slave bus
);
  localparam int unsigned BusNbs = AxiDataWidth / 4;
  localparam int unsigned BufNbs = Dlen / 4 * NrLanes;
  localparam int unsigned PW     = $clog2(BufNbs);
  localparam int unsigned BW     = $clog2(BusNbs);
  localparam int unsigned CW     = ((PW > BW) ? PW : BW) + 2;  // room for sums
  localparam int unsigned QW     = $clog2(NrBufs);
  localparam int unsigned IW     = $clog2(InfoDepth);

  typedef enum logic [1:0] {IDLE, SERIAL, GATHER} state_e;

  // ---------------- meta FIFO ----------------
  logic [PW-1:0] info_ptr_mem [InfoDepth];
  logic [1:0]    info_sew_mem [InfoDepth];
  logic [IW:0]   info_wr_reg, info_rd_reg;
  logic          info_full, info_empty, info_push, info_pop;
  logic          live_reg;  // keeps meta_ready low while in reset
  logic [31:0]   meta_shift;

  assign info_empty = (info_wr_reg == info_rd_reg);
  assign info_full  = (info_wr_reg[IW] != info_rd_reg[IW]) &&
                      (info_wr_reg[IW-1:0] == info_rd_reg[IW-1:0]);
  assign bus.meta_ready = live_reg && !info_full;
  assign info_push  = bus.meta_valid && bus.meta_ready;
  assign meta_shift = (32'(bus.meta_vstart) << bus.meta_sew) << 1;

  always_ff @(posedge clk_i) begin
    if (info_push) begin
      info_ptr_mem[info_wr_reg[IW-1:0]] <= meta_shift[PW-1:0];
      info_sew_mem[info_wr_reg[IW-1:0]] <= bus.meta_sew;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      info_wr_reg <= '0;
      info_rd_reg <= '0;
      live_reg    <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      if (info_push) info_wr_reg <= info_wr_reg + 1'b1;
      if (info_pop)  info_rd_reg <= info_rd_reg + 1'b1;
    end
  end

  // ---------------- buffer ring pointers ----------------
  logic [QW:0]   enq_ptr_reg, deq_ptr_reg, count;
  logic          full, enq, deq;
  logic [QW-1:0] enq_idx, deq_idx;

  assign count   = enq_ptr_reg - deq_ptr_reg;
  assign full    = (count == (QW+1)'(NrBufs));
  assign enq_idx = enq_ptr_reg[QW-1:0];
  assign deq_idx = deq_ptr_reg[QW-1:0];
  assign deq     = bus.out_valid && bus.out_ready;

  // ---------------- FSM ----------------
  state_e        state_reg, state_next;
  logic [PW-1:0] seq_ptr_reg, seq_ptr_next;
  logic [BW:0]   bus_cnt_reg, bus_cnt_next;
  logic [1:0]    sew_reg, sew_next;
  logic          beat_ok, final_beat, consume, wr_en;
  logic [CW-1:0] lo, hi, avail, space, elem, seq_ext, wr_cnt, src_base;

  assign beat_ok    = bus.r_valid && bus.txn_valid && !full;
  assign final_beat = bus.txn_final && (bus.txn_rmn_beat == 8'd0);
  assign seq_ext    = CW'(seq_ptr_reg);
  assign lo         = bus.txn_head ? CW'(bus.txn_off) : '0;
  assign hi         = (bus.txn_rmn_beat == 8'd0) ? CW'(bus.txn_lbn) : CW'(BusNbs);
  assign avail      = hi - lo - CW'(bus_cnt_reg);
  assign space      = CW'(BufNbs) - seq_ext;
  assign elem       = CW'(2) << sew_reg;
  assign bus.r_ready   = consume;
  assign bus.txn_ready = consume;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      seq_ptr_reg <= '0;
      bus_cnt_reg <= '0;
      sew_reg     <= '0;
      enq_ptr_reg <= '0;
      deq_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      seq_ptr_reg <= seq_ptr_next;
      bus_cnt_reg <= bus_cnt_next;
      sew_reg     <= sew_next;
      if (enq) enq_ptr_reg <= enq_ptr_reg + 1'b1;
      if (deq) deq_ptr_reg <= deq_ptr_reg + 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    seq_ptr_next = seq_ptr_reg;
    bus_cnt_next = bus_cnt_reg;
    sew_next     = sew_reg;
    info_pop     = 1'b0;
    consume      = 1'b0;
    wr_en        = 1'b0;
    enq          = 1'b0;
    wr_cnt       = '0;
    src_base     = '0;
    case (state_reg)
      IDLE: begin
        // one bubble per request: meta is loaded, no beat taken
        if (bus.txn_valid && !info_empty) begin
          info_pop     = 1'b1;
          seq_ptr_next = info_ptr_mem[info_rd_reg[IW-1:0]];
          sew_next     = info_sew_mem[info_rd_reg[IW-1:0]];
          bus_cnt_next = '0;
          state_next   = bus.txn_gather ? GATHER : SERIAL;
        end
      end
      SERIAL: begin
        if (beat_ok) begin
          wr_en    = 1'b1;
          src_base = lo + CW'(bus_cnt_reg);
          if (avail > space) begin
            // beat overflows the buffer: fill it, keep the beat for the rest
            wr_cnt       = space;
            bus_cnt_next = (BW+1)'(CW'(bus_cnt_reg) + space);
            enq          = 1'b1;
            seq_ptr_next = '0;
          end else begin
            wr_cnt       = avail;
            consume      = 1'b1;
            bus_cnt_next = '0;
            seq_ptr_next = PW'(seq_ext + avail);
            if (avail == space || final_beat) begin
              enq          = 1'b1;
              seq_ptr_next = '0;
            end
            if (final_beat) state_next = IDLE;
          end
        end
      end
      GATHER: begin
        if (beat_ok) begin
          wr_en        = 1'b1;
          wr_cnt       = elem;
          src_base     = CW'(bus.txn_off);
          consume      = 1'b1;
          seq_ptr_next = PW'(seq_ext + elem);
          if (seq_ext + elem == CW'(BufNbs) || final_beat) begin
            enq          = 1'b1;
            seq_ptr_next = '0;
          end
          if (final_beat) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- write datapath ----------------
  // bus_shift nibble j = bus nibble src_base+j; placed aligns it to the
  // buffer width, then it is rotated up to seq_ptr.
  logic [AxiDataWidth-1:0] bus_shift;
  logic [BufNbs*4-1:0]     placed, wr_nb, nib_mask;
  logic [BufNbs:0]         ones_ext;
  logic [BufNbs-1:0]       wr_mask;

  assign bus_shift = bus.r_data >> {src_base, 2'b00};
  assign wr_nb     = placed << {seq_ptr_reg, 2'b00};
  assign ones_ext  = ((BufNbs+1)'(1) << wr_cnt) - 1'b1;
  assign wr_mask   = ones_ext[BufNbs-1:0] << seq_ptr_reg;

  for (genvar gi = 0; gi < BufNbs; gi++) begin : g_nib
    if (gi < BusNbs) begin : g_src
      assign placed[gi*4 +: 4] = bus_shift[gi*4 +: 4];
    end else begin : g_zero
      assign placed[gi*4 +: 4] = 4'h0;
    end
    assign nib_mask[gi*4 +: 4] = {4{wr_mask[gi]}};
  end

  // ---------------- buffer ring storage ----------------
  logic [BufNbs*4-1:0] buf_nb_reg [NrBufs];
  logic [BufNbs-1:0]   buf_en_reg [NrBufs];

  for (genvar gi = 0; gi < NrBufs; gi++) begin : g_buf
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        buf_nb_reg[gi] <= '0;
        buf_en_reg[gi] <= '0;
      end else if (deq && deq_idx == QW'(gi)) begin
        buf_nb_reg[gi] <= '0;
        buf_en_reg[gi] <= '0;
      end else if (wr_en && enq_idx == QW'(gi)) begin
        buf_nb_reg[gi] <= (buf_nb_reg[gi] & ~nib_mask) | (wr_nb & nib_mask);
        buf_en_reg[gi] <= buf_en_reg[gi] | wr_mask;
      end
    end
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_nb    = buf_nb_reg[deq_idx];
  assign bus.out_en    = buf_en_reg[deq_idx];
  assign bus.buf_cnt   = count;

  gather_off_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == GATHER && beat_ok) |-> (CW'(bus.txn_off) + elem <= CW'(BusNbs)));
endmodule

// File: doc/seq_load_unit.md
Name: seq_load_unit

Overview:
- Parametrised successor of the sequential load data controller in the VLSU load path.
- Packs nibbles from AXI R beats into a ring of NrBufs lane-wide sequential buffers, which drain to the shuffle unit.
- Adds the gather (element-per-beat) commit mode the previous generation lacked, and a configurable buffer depth.
- Gates per-request init on meta availability, so the controller never starts on stale metadata.

Parameters:
NrLanes, 4, number of vector lanes
Dlen, 64, bits per lane per buffer entry
AxiDataWidth, 128, R data width in bits; BusNbs = AxiDataWidth/4
NrBufs, 2, sequential buffer ring depth (power of 2, >=2)
InfoDepth, 4, meta FIFO depth
Derived: BufNbs = Dlen/4*NrLanes (64 at defaults), PW = $clog2(BufNbs), BW = $clog2(BusNbs)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
r_valid_i  in  1  AXI R valid
r_ready_o  out  1  AXI R ready
r_data_i  in  AxiDataWidth  AXI R data
txn_valid_i  in  1  beat-control valid
txn_ready_o  out  1  beat-control ready (consumed together with R beat)
txn_head_i  in  1  first beat of a burst
txn_final_i  in  1  burst is last of request
txn_rmn_beat_i  in  8  beats remaining after this one
txn_off_i  in  BW  nibble offset of first valid nibble (head/gather)
txn_lbn_i  in  BW+1  exclusive upper nibble bound of last beat
txn_gather_i  in  1  1 = gather mode for this request
meta_valid_i  in  1  request meta valid
meta_ready_o  out  1  meta FIFO not full
meta_vstart_i  in  16  start element index
meta_sew_i  in  2  element width log2(bytes)
out_valid_o  out  1  buffer available to shuffle unit
out_ready_i  in  1  shuffle unit accepts
out_nb_o  out  BufNbs*4  buffer nibble data
out_en_o  out  BufNbs  per-nibble valid
buf_cnt_o  out  $clog2(NrBufs)+1  occupied buffers

Behaviour:
- Reset:
  - Asynchronous, active-low on rst_ni; clock clk_i.
  - State IDLE; all buffers, en, pointers and counters cleared; meta FIFO emptied.
  - All valid/ready outputs 0; buf_cnt_o = 0.
  - A reset mid-request discards all partial data.
- Meta FIFO (InfoDepth):
  - Each entry stores ptr = (vstart << sew << 1) mod BufNbs, plus sew.
  - meta_ready_o = !full.
- FSM IDLE:
  - Transition fires when txn_valid_i && FIFO non-empty.
  - On it: pop the FIFO, load seq_ptr and sew_r, clear bus_cnt.
  - Next state: GATHER if txn_gather_i, else SERIAL.
  - No beat is consumed in IDLE (one bubble per request).
- SERIAL:
  - Bounds: lo = txn_head_i ? txn_off_i : 0; hi = (rmn==0) ? txn_lbn_i : BusNbs.
  - avail = hi - lo - bus_cnt; space = BufNbs - seq_ptr. Commit requires r_valid_i && txn_valid_i && !full.
  - If avail > space: write space nibbles; bus_cnt += space; enq; seq_ptr = 0; beat not consumed.
  - Otherwise: write avail nibbles; handshake r/txn; bus_cnt = 0; seq_ptr += avail.
  - Also enq with seq_ptr = 0 if avail == space or the beat is final.
- GATHER:
  - Per beat, write E = 2 << sew_r nibbles from bus offset txn_off_i to seq_ptr.
  - Handshake the beat; seq_ptr += E.
  - Enq when seq_ptr + E == BufNbs or the beat is final.
  - Commit requires r_valid_i && txn_valid_i && !full.
  - txn_off_i + E > BusNbs is an assertion failure.
- Final beat:
  - Condition: txn_final_i && rmn == 0, handshaken.
  - Enqueues the current buffer, even if partial; FSM returns to IDLE.
- Buffer ring:
  - Enq/deq pointers carry wrap flags; full = count == NrBufs.
  - out_valid_o = count != 0; out_* driven from the deq entry, registered.
  - A deq handshake clears that entry's nb and en in the same cycle.
  - Simultaneous enq + deq: count unchanged.
  - Full is evaluated on registered count; there is no same-cycle bypass.
- Writes set en for exactly the committed nibble range; other en bits retain their value.
- Arithmetic: all pointer/bound arithmetic is unsigned, one bit wider than the operand; seq_ptr wraps only via an explicit zero on enq.

Test Plan:
1. Serial aligned, 2 beats: vstart=0, sew=0, beats A then B, off=0, lbn=32, final → one output with out_en_o = all 64 ones, nibbles 0..31 = A, 32..63 = B, plus 1 IDLE bubble.
2. Unaligned head, single final beat: vstart=4, sew=0 (ptr=8), off=8, lbn=32 → en bits 8..31 only; nb[8..31] = bus nibbles 8..31.
3. Split across buffers: vstart=24, sew=0 (ptr=48), 1 final beat, 32 nibbles:
   - Cycle 1: bus nibbles 0..15 → buf0[48..63], buf0 enq, r_ready_o=0.
   - Cycle 2: bus nibbles 16..31 → buf1[0..15], r_ready_o=1, buf1 enq.
4. Backpressure, NrBufs=2, out_ready_i=0: fill 2 buffers → buf_cnt_o=2, r_ready_o stays 0. Raise out_ready_i → deq, then resume in the next cycle; no data is lost or duplicated.
5. Gather, sew=2 (E=8), vstart=0, 8 beats with off=16 → after beat 8 one enq; buffer nibbles 8k..8k+7 = beat k nibbles 16..23.
6. Reset mid-SERIAL, partial buffer and meta FIFO holding 2 entries → next cycle: out_valid_o=0, r_ready_o=0, buf_cnt_o=0, meta_ready_o=1. A fresh request then completes correctly.
